sdcard_resp_rx: RTL and testbench
=================================

SDCARD_RESP_RX -- requirements
Module: sdcard_resp_rx

Interface
REQ-001 SHALL have port PCLK_i, input, 1 bit: system clock; all logic is rising-edge.
REQ-002 SHALL have port PRESETn_i, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port sd_clk_en_i, input, 1 bit: one-PCLK strobe marking the SD-clock sampling edge.
REQ-004 SHALL have port cmd_in_i, input, 1 bit: already-synchronised SD CMD line level.
REQ-005 SHALL have port rx_start_i, input, 1 bit: one-cycle pulse that arms reception after a command is sent.
REQ-006 SHALL have port resp_long_i, input, 1 bit: 136-bit R2 frame when 1, 48-bit frame when 0; sampled on rx_start_i.
REQ-007 SHALL have port crc_check_en_i, input, 1 bit: enables the CRC7 check (0 for R3); sampled on rx_start_i.
REQ-008 SHALL have port timeout_i, input, 16 bits: Ncr limit counted in strobes; 0 disables the timeout; sampled on rx_start_i.
REQ-009 SHALL have port abort_i, input, 1 bit: synchronous abort.
REQ-010 SHALL have port rx_busy_o, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port done_o, output, 1 bit: one-cycle pulse when a frame completes or times out.
REQ-012 SHALL have port resp_idx_o, output, 6 bits: command index field (short frames).
REQ-013 SHALL have port resp_data_o, output, 128 bits: response payload.
REQ-014 SHALL have port err_o, output, 4 bits: {timeout, crc, end_bit, tx_bit}.

Function
REQ-015 SHALL implement the FSM IDLE -> WAIT_START -> RX_BITS -> CHECK -> IDLE; all bit sampling occurs only on cycles with sd_clk_en_i=1.
REQ-016 SHALL, when rx_start_i=1 in IDLE: latch mode inputs, clear err_o, resp_idx_o, resp_data_o and the strobe counter, and enter WAIT_START.
REQ-017 SHALL ignore rx_start_i when not in IDLE.
REQ-018 SHALL, in WAIT_START, take a strobe with cmd_in_i=0 as the start bit and enter RX_BITS with bit count 1.
REQ-019 SHALL, in WAIT_START, increment the 16-bit counter on each strobe with cmd_in_i=1.
REQ-020 SHALL, in WAIT_START with timeout_i != 0, on the strobe where the counter would reach timeout_i: set err_o[3], pulse done_o and return to IDLE.
REQ-021 SHALL receive frame bits MSB-first; the frame length is 48 (short) or 136 (long) bits including the start bit; the bit counter is 8 bits wide.
REQ-022 SHALL decode a short frame as: bit 46 = tx bit (must be 0, else err_o[0]); bits 45:40 -> resp_idx_o; bits 39:8 -> resp_data_o[31:0] with resp_data_o[127:32]=0; bits 7:1 = CRC7; bit 0 = end bit.
REQ-023 SHALL decode a long frame as: bit 134 = tx bit (err_o[0] if 1); bits 133:128 = reserved, ignored; bits 127:0 -> resp_data_o[127:0] (CRC7 in [7:1], end bit in [0]); resp_idx_o=0.
REQ-024 SHALL compute CRC7 (polynomial x^7+x^3+1, initial value 0) serially over frame bits 47:8 for short frames and bits 127:8 for long frames.
REQ-025 SHALL set err_o[2] on a CRC7 mismatch only when crc_check_en was latched as 1.
REQ-026 SHALL set err_o[1] when the end bit is 0.
REQ-027 SHALL enter CHECK on the cycle after the end bit is sampled; CHECK SHALL last exactly one PCLK, pulse done_o, update err_o, and return to IDLE.
REQ-028 SHALL hold resp_data_o, resp_idx_o and err_o stable from done_o until the next accepted rx_start_i.
REQ-029 SHALL, on abort_i=1 in any state, go to IDLE on the next edge with no done_o and no err_o change; abort_i takes priority over rx_start_i and over a strobe in the same cycle.
REQ-030 SHALL keep the state unchanged for any number of PCLK cycles without a strobe, with no counter advance.

Reset
REQ-031 SHALL asynchronously force state IDLE, rx_busy_o=0, done_o=0, err_o=0, resp_idx_o=0, resp_data_o=0, and all counters and the CRC register to 0.
REQ-032 SHALL, if reset is asserted mid-frame, discard the partial frame and require a new rx_start_i after release.

Structure
REQ-033 SHALL place the FSM state enum, frame lengths (48, 136), the CRC7 polynomial constant and the err_o bit indices in the shared sdcard package.
REQ-034 SHALL implement CRC7 in one sub-module, sdcard_crc7 (inputs clear, enable, data bit; output crc[6:0]), reusable by the command transmitter.

Verification
REQ-035 SHALL test a short frame 0x08_000001AA_13 (R7, CRC 0x09) with CRC on -> done_o after bit 48; resp_idx_o=8; resp_data_o[31:0]=0x000001AA; err_o=0.
REQ-036 SHALL test the same frame with argument bit 0 flipped (0x08_000001AB_13) -> err_o=4'b0100; with crc_check_en_i=0 -> err_o=0.
REQ-037 SHALL test timeout_i=64 with the CMD line held high -> done_o on the 64th strobe, err_o=4'b1000, rx_busy_o=0 on the next cycle.
REQ-038 SHALL test a long R2 frame with a random 120-bit CID plus its correct CRC7 and end bit 1 -> resp_data_o equals the 128 transmitted bits; err_o=0.
REQ-039 SHALL test end bit=0 together with tx bit=1 -> err_o=4'b0011.
REQ-040 SHALL test abort_i asserted at bit 20, then reset asserted at bit 30 of a new frame -> no done_o; IDLE; all outputs 0.

Source files
------------

// File: rtl/sdcard_pkg.sv
// sdcard_pkg: shared types and constants for the SD-card command path.
package sdcard_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_START, RX_BITS, CHECK} state_e;
  localparam logic [7:0] SHORT_LEN = 8'd48;
  localparam logic [7:0] LONG_LEN = 8'd136;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int ERR_TX = 0;
  localparam int ERR_END = 1;
  localparam int ERR_CRC = 2;
  localparam int ERR_TIMEOUT = 3;
endpackage

// File: rtl/sdcard_crc7.sv
// sdcard_crc7: serial CRC7 (x^7+x^3+1, zero seed), one bit per enabled cycle.
module sdcard_crc7
  import sdcard_pkg::*;
(
  input  logic       PCLK_i,
  input  logic       PRESETn_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);
  logic [6:0] crc_q, crc_d;
  logic fb;
  always_comb begin
    fb = crc_q[6] ^ din_i;
    crc_d = clear_i ? 7'd0 : en_i ? ({crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0)) : crc_q;
  end
  always_ff @(posedge PCLK_i or negedge PRESETn_i)
    if (!PRESETn_i) crc_q <= '0;
    else crc_q <= crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/sdcard_resp_rx.sv
// sdcard_resp_rx: receives and checks 48/136-bit SD responses on the CMD line.
module sdcard_resp_rx
  import sdcard_pkg::*;
(
  input  logic         PCLK_i,
  input  logic         PRESETn_i,
  input  logic         sd_clk_en_i,
  input  logic         cmd_in_i,
  input  logic         rx_start_i,
  input  logic         resp_long_i,
  input  logic         crc_check_en_i,
  input  logic [15:0]  timeout_i,
  input  logic         abort_i,
  output logic         rx_busy_o,
  output logic         done_o,
  output logic [5:0]   resp_idx_o,
  output logic [127:0] resp_data_o,
  output logic [3:0]   err_o
);
  state_e state_q, state_d;
  logic long_q, long_d, crc_en_q, crc_en_d, tx_q, tx_d, done_q, done_d;
  logic [15:0] to_q, to_d, ncr_q, ncr_d;
  logic [7:0] cnt_q, cnt_d, len;
  logic [126:0] sh_q, sh_d;
  logic [127:0] sh_n, data_q, data_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] err_q, err_d;
  logic [6:0] crc;
  logic start, rx, crc_feed, last;
  assign start = state_q == IDLE && rx_start_i && !abort_i;
  assign rx = state_q == RX_BITS && sd_clk_en_i && !abort_i;
  assign len = long_q ? LONG_LEN : SHORT_LEN;
  assign last = cnt_q + 8'd1 == len;
  assign sh_n = {sh_q, cmd_in_i};
  // CRC spans everything up to the CRC field; the zero start bit leaves a zero seed unchanged
  assign crc_feed = rx && (long_q ? (cnt_q >= 8'd8 && cnt_q <= 8'd127) : cnt_q <= 8'd39);
  sdcard_crc7 u_crc (
    .PCLK_i   (PCLK_i),
    .PRESETn_i(PRESETn_i),
    .clear_i  (start),
    .en_i     (crc_feed),
    .din_i    (cmd_in_i),
    .crc_o    (crc)
  );
  always_comb begin
    state_d = state_q;
    long_d = long_q;
    crc_en_d = crc_en_q;
    tx_d = tx_q;
    done_d = 1'b0;
    to_d = to_q;
    ncr_d = ncr_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    data_d = data_q;
    idx_d = idx_q;
    err_d = err_q;
    if (abort_i) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (rx_start_i) begin
            state_d = WAIT_START;
            long_d = resp_long_i;
            crc_en_d = crc_check_en_i;
            to_d = timeout_i;
            ncr_d = '0;
            cnt_d = '0;
            data_d = '0;
            idx_d = '0;
            err_d = '0;
          end
        WAIT_START:
          if (sd_clk_en_i) begin
            if (!cmd_in_i) begin
              state_d = RX_BITS;
              cnt_d = 8'd1;
            end else begin
              ncr_d = ncr_q + 16'd1;
              if (to_q != 16'd0 && ncr_d == to_q) begin
                state_d = IDLE;
                done_d = 1'b1;
                err_d[ERR_TIMEOUT] = 1'b1;
              end
            end
          end
        RX_BITS:
          if (sd_clk_en_i) begin
            sh_d = sh_n[126:0];
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd1) tx_d = cmd_in_i;
            // results are loaded with the end bit so they are valid while CHECK pulses done
            if (last) begin
              state_d = CHECK;
              done_d = 1'b1;
              err_d[ERR_TX] = tx_q;
              err_d[ERR_END] = !cmd_in_i;
              err_d[ERR_CRC] = crc_en_q && crc != sh_n[7:1];
              idx_d = long_q ? 6'd0 : sh_n[45:40];
              data_d = long_q ? sh_n : {96'd0, sh_n[39:8]};
            end
          end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge PCLK_i or negedge PRESETn_i)
    if (!PRESETn_i) begin
      state_q <= IDLE;
      long_q <= 1'b0;
      crc_en_q <= 1'b0;
      tx_q <= 1'b0;
      done_q <= 1'b0;
      to_q <= '0;
      ncr_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      long_q <= long_d;
      crc_en_q <= crc_en_d;
      tx_q <= tx_d;
      done_q <= done_d;
      to_q <= to_d;
      ncr_q <= ncr_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      data_q <= data_d;
      idx_q <= idx_d;
      err_q <= err_d;
    end
  assign rx_busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign resp_idx_o = idx_q;
  assign resp_data_o = data_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_sdcard_resp_rx.sv
// tb_sdcard_resp_rx: directed frames with a scoreboard of expected completions.
module tb_sdcard_resp_rx;
  logic PCLK_i = 1'b0, PRESETn_i = 1'b0;
  logic sd_clk_en_i = 1'b0, cmd_in_i = 1'b1, rx_start_i = 1'b0, resp_long_i = 1'b0;
  logic crc_check_en_i = 1'b0, abort_i = 1'b0;
  logic [15:0] timeout_i = '0;
  logic rx_busy_o, done_o;
  logic [5:0] resp_idx_o;
  logic [127:0] resp_data_o;
  logic [3:0] err_o;
  typedef struct {
    logic [5:0] idx;
    logic [127:0] data;
    logic [3:0] err;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_done = 0, n_push = 0;
  sdcard_resp_rx dut (
    .PCLK_i        (PCLK_i),
    .PRESETn_i     (PRESETn_i),
    .sd_clk_en_i   (sd_clk_en_i),
    .cmd_in_i      (cmd_in_i),
    .rx_start_i    (rx_start_i),
    .resp_long_i   (resp_long_i),
    .crc_check_en_i(crc_check_en_i),
    .timeout_i     (timeout_i),
    .abort_i       (abort_i),
    .rx_busy_o     (rx_busy_o),
    .done_o        (done_o),
    .resp_idx_o    (resp_idx_o),
    .resp_data_o   (resp_data_o),
    .err_o         (err_o)
  );
  always #5 PCLK_i = ~PCLK_i;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [6:0] crc7(input logic [135:0] f, input int hi);
    logic [6:0] c = '0;
    logic fb;
    for (int i = hi; i >= 8; i--) begin
      fb = c[6] ^ f[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction
  always @(negedge PCLK_i)
    if (PRESETn_i && done_o) begin
      if (q.size() == 0) chk("unexpected_done", 128'(done_o), 128'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        n_done++;
        chk("sb_idx", 128'(resp_idx_o), 128'(e.idx));
        chk("sb_data", resp_data_o, e.data);
        chk("sb_err", 128'(err_o), 128'(e.err));
      end
    end
  task automatic push(input logic [5:0] idx, input logic [127:0] data, input logic [3:0] err);
    exp_t e;
    e.idx = idx;
    e.data = data;
    e.err = err;
    q.push_back(e);
    n_push++;
  endtask
  task automatic send_bit(input logic b);
    @(negedge PCLK_i);
    cmd_in_i = b;
    sd_clk_en_i = 1'b1;
    @(negedge PCLK_i);
    sd_clk_en_i = 1'b0;
    @(negedge PCLK_i);
  endtask
  task automatic arm(input logic lng, input logic ce, input logic [15:0] to);
    @(negedge PCLK_i);
    rx_start_i = 1'b1;
    resp_long_i = lng;
    crc_check_en_i = ce;
    timeout_i = to;
    @(negedge PCLK_i);
    rx_start_i = 1'b0;
    resp_long_i = ~lng;
    crc_check_en_i = ~ce;
    timeout_i = 16'd3;
  endtask
  task automatic run_frame(input logic [135:0] f, input int len, input logic lng, input logic ce);
    arm(lng, ce, 16'd0);
    repeat (3) send_bit(1'b1);
    for (int i = len - 1; i > 0; i--) send_bit(f[i]);
    @(negedge PCLK_i);
    cmd_in_i = f[0];
    sd_clk_en_i = 1'b1;
    @(negedge PCLK_i);
    sd_clk_en_i = 1'b0;
    chk("done_after_end_bit", 128'(done_o), 128'd1);
    chk("busy_in_check", 128'(rx_busy_o), 128'd1);
    @(negedge PCLK_i);
    chk("done_one_cycle", 128'(done_o), 128'd0);
    chk("idle_after_check", 128'(rx_busy_o), 128'd0);
  endtask
  initial begin
    logic [135:0] f;
    logic [127:0] r;
    repeat (3) @(negedge PCLK_i);
    chk("rst_busy", 128'(rx_busy_o), 128'd0);
    chk("rst_done", 128'(done_o), 128'd0);
    chk("rst_err", 128'(err_o), 128'd0);
    chk("rst_idx", 128'(resp_idx_o), 128'd0);
    chk("rst_data", resp_data_o, 128'd0);
    PRESETn_i = 1'b1;
    repeat (2) @(negedge PCLK_i);
    f = {88'd0, 48'h08_000001AA_13};
    push(6'd8, 128'h1AA, 4'b0000);
    run_frame(f, 48, 1'b0, 1'b1);
    f = {88'd0, 48'h08_000001AB_13};
    push(6'd8, 128'h1AB, 4'b0100);
    run_frame(f, 48, 1'b0, 1'b1);
    push(6'd8, 128'h1AB, 4'b0000);
    run_frame(f, 48, 1'b0, 1'b0);
    push(6'd0, 128'd0, 4'b1000);
    arm(1'b0, 1'b1, 16'd64);
    repeat (63) send_bit(1'b1);
    chk("ncr_busy_before_limit", 128'(rx_busy_o), 128'd1);
    @(negedge PCLK_i);
    sd_clk_en_i = 1'b1;
    @(negedge PCLK_i);
    sd_clk_en_i = 1'b0;
    chk("timeout_done", 128'(done_o), 128'd1);
    @(negedge PCLK_i);
    chk("timeout_idle", 128'(rx_busy_o), 128'd0);
    chk("timeout_err_held", 128'(err_o), 128'h8);
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    f = '0;
    f[133:128] = 6'h3F;
    f[127:8] = r[119:0];
    f[7:1] = crc7(f, 127);
    f[0] = 1'b1;
    push(6'd0, f[127:0], 4'b0000);
    run_frame(f, 136, 1'b1, 1'b1);
    repeat (5) @(negedge PCLK_i);
    chk("r2_data_held", resp_data_o, f[127:0]);
    f = {88'd0, 8'h48, 32'h1AA, 8'h00};
    f[7:1] = crc7(f, 47);
    push(6'd8, 128'h1AA, 4'b0011);
    run_frame(f, 48, 1'b0, 1'b1);
    f = {88'd0, 48'h08_000001AA_13};
    arm(1'b0, 1'b1, 16'd0);
    for (int i = 47; i > 27; i--) send_bit(f[i]);
    @(negedge PCLK_i);
    abort_i = 1'b1;
    sd_clk_en_i = 1'b1;
    cmd_in_i = f[27];
    @(negedge PCLK_i);
    abort_i = 1'b0;
    sd_clk_en_i = 1'b0;
    chk("abort_idle", 128'(rx_busy_o), 128'd0);
    chk("abort_err_kept", 128'(err_o), 128'd0);
    for (int i = 26; i >= 0; i--) send_bit(f[i]);
    chk("abort_no_restart", 128'(rx_busy_o), 128'd0);
    arm(1'b0, 1'b1, 16'd0);
    for (int i = 47; i > 17; i--) send_bit(f[i]);
    chk("busy_mid_frame", 128'(rx_busy_o), 128'd1);
    #2 PRESETn_i = 1'b0;
    #1;
    chk("rst_mid_busy", 128'(rx_busy_o), 128'd0);
    chk("rst_mid_idx", 128'(resp_idx_o), 128'd0);
    chk("rst_mid_data", resp_data_o, 128'd0);
    chk("rst_mid_err", 128'(err_o), 128'd0);
    @(negedge PCLK_i);
    PRESETn_i = 1'b1;
    for (int i = 17; i >= 0; i--) send_bit(f[i]);
    chk("post_rst_idle", 128'(rx_busy_o), 128'd0);
    chk("post_rst_done", 128'(done_o), 128'd0);
    chk("post_rst_err", 128'(err_o), 128'd0);
    chk("post_rst_data", resp_data_o, 128'd0);
    repeat (3) @(negedge PCLK_i);
    chk("done_count", 128'(n_done), 128'(n_push));
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
